// File: rtl/burst_ram_pkg.sv
// Shared widths and pointer helper for the burst RAM model.
package burst_ram_pkg;
   localparam int WORD_W = 64;
   localparam int MASK_W = 8;

   function automatic int wrap_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction
endpackage

// File: rtl/burst_ram.sv
// Burst-oriented 64-bit RAM model with calibration delay and fixed read latency.
//
// state        | meaning
// S_INIT       | calibration countdown after reset
// S_IDLE       | waiting for a command
// S_READ_DELAY | read latency countdown
// S_READ_BURST | streaming read words out
// S_WRITE_BURST| capturing remaining write words
module burst_ram
   import burst_ram_pkg::*;
#(
   parameter int DEPTH_BITWIDTH           = 21,
   parameter int MEM_DEPTH                = 65536,
   parameter     DATA_FILE                = "",
   parameter int CYCLES_BEFORE_DATA_VALID = 12,
   parameter int CYCLES_BEFORE_INITIATED  = 10,
   parameter int BURST_COUNT              = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd,
   input  logic                      cmd_en,
   input  logic [DEPTH_BITWIDTH-1:0] addr,
   input  logic [WORD_W-1:0]         wr_data,
   input  logic [MASK_W-1:0]         data_mask,
   output logic [WORD_W-1:0]         rd_data,
   output logic                      rd_data_valid,
   output logic                      init_calib,
   output logic                      busy
);
   localparam int PTR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CNT_W = 16;

   typedef enum logic [4:0] {
      S_INIT        = 5'b00001,
      S_IDLE        = 5'b00010,
      S_READ_DELAY  = 5'b00100,
      S_READ_BURST  = 5'b01000,
      S_WRITE_BURST = 5'b10000
   } state_t;

   state_t             r_state, w_state_n;
   logic [CNT_W-1:0]   r_cnt, w_cnt_n, w_init_cnt;
   logic [PTR_W-1:0]   r_ptr, w_ptr_n, w_ptr_inc, w_addr_mod, w_addr_inc, w_waddr;
   logic               r_valid, w_valid_n;
   logic               r_calib, w_calib_n;
   logic               r_armed, w_armed_n;
   logic               w_we, w_rd_en;
   logic [WORD_W-1:0]  r_rd_data;
   logic [WORD_W-1:0]  r_mem [MEM_DEPTH];
   logic               w_unused_mask;

   assign w_unused_mask = ^data_mask;
   assign w_addr_mod    = PTR_W'(addr % DEPTH_BITWIDTH'(MEM_DEPTH));
   assign w_addr_inc    = PTR_W'(wrap_inc(32'(w_addr_mod), MEM_DEPTH));
   assign w_ptr_inc     = PTR_W'(wrap_inc(32'(r_ptr), MEM_DEPTH));
   // First INIT cycle after reset loads the calibration count instead of using the cleared counter.
   assign w_init_cnt    = r_armed ? r_cnt : CNT_W'(CYCLES_BEFORE_INITIATED);

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_ptr_n   = r_ptr;
      w_valid_n = r_valid;
      w_calib_n = r_calib;
      w_armed_n = r_armed;
      w_we      = 1'b0;
      w_waddr   = r_ptr;
      w_rd_en   = 1'b0;
      case (r_state)
         S_INIT: begin
            w_armed_n = 1'b1;
            if (w_init_cnt <= CNT_W'(1)) begin
               w_state_n = S_IDLE;
               w_calib_n = 1'b1;
               w_cnt_n   = '0;
            end else begin
               w_cnt_n = w_init_cnt - CNT_W'(1);
            end
         end
         S_IDLE: begin
            if (cmd_en) begin
               if (cmd) begin
                  w_we    = 1'b1;
                  w_waddr = w_addr_mod;
                  w_ptr_n = w_addr_inc;
                  if (BURST_COUNT > 1) begin
                     w_state_n = S_WRITE_BURST;
                     w_cnt_n   = CNT_W'(BURST_COUNT - 2);
                  end
               end else begin
                  w_ptr_n   = w_addr_mod;
                  w_cnt_n   = CNT_W'(CYCLES_BEFORE_DATA_VALID - 1);
                  w_state_n = S_READ_DELAY;
               end
            end
         end
         S_READ_DELAY: begin
            if (r_cnt == '0) begin
               w_valid_n = 1'b1;
               w_rd_en   = 1'b1;
               w_ptr_n   = w_ptr_inc;
               w_cnt_n   = CNT_W'(BURST_COUNT - 1);
               w_state_n = S_READ_BURST;
            end else begin
               w_cnt_n = r_cnt - CNT_W'(1);
            end
         end
         S_READ_BURST: begin
            if (r_cnt == '0) begin
               w_valid_n = 1'b0;
               w_state_n = S_IDLE;
            end else begin
               w_rd_en = 1'b1;
               w_ptr_n = w_ptr_inc;
               w_cnt_n = r_cnt - CNT_W'(1);
            end
         end
         S_WRITE_BURST: begin
            w_we    = 1'b1;
            w_ptr_n = w_ptr_inc;
            if (r_cnt == '0) w_state_n = S_IDLE;
            else             w_cnt_n   = r_cnt - CNT_W'(1);
         end
         default: w_state_n = S_INIT;
      endcase
      // A write landing on the reset edge is part of the aborted burst.
      if (rst) w_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_INIT;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_valid <= 1'b0;
         r_calib <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_ptr   <= w_ptr_n;
         r_valid <= w_valid_n;
         r_calib <= w_calib_n;
         r_armed <= w_armed_n;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= wr_data;
      if (rst)          r_rd_data <= '0;
      else if (w_rd_en) r_rd_data <= r_mem[r_ptr];
   end

   assign rd_data       = r_rd_data;
   assign rd_data_valid = r_valid;
   assign init_calib    = r_calib;
   assign busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_burst_ram.sv
// Directed self-checking bench for burst_ram with default parameters.
module tb_burst_ram;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd = 1'b0;
   logic        cmd_en = 1'b0;
   logic [20:0] addr = '0;
   logic [63:0] wr_data = '0;
   logic [7:0]  data_mask = 8'hFF;
   logic [63:0] rd_data;
   logic        rd_data_valid;
   logic        init_calib;
   logic        busy;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] got [4];
   int          first_k;
   int          nvalid;
   int          seen;
   logic [63:0] second_word;

   localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
   localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
   localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
   localparam logic [63:0] W4 = 64'h4444_4444_4444_4444;
   localparam logic [63:0] A1 = 64'hA0A0_0000_0000_0001;
   localparam logic [63:0] A2 = 64'hA0A0_0000_0000_0002;
   localparam logic [63:0] A3 = 64'hA0A0_0000_0000_0003;
   localparam logic [63:0] A4 = 64'hA0A0_0000_0000_0004;
   localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

   burst_ram dut (
      .clk           (clk),
      .rst           (rst),
      .cmd           (cmd),
      .cmd_en        (cmd_en),
      .addr          (addr),
      .wr_data       (wr_data),
      .data_mask     (data_mask),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .init_calib    (init_calib),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Release reset and count out calibration; optionally fire a write command at cycle pulse_k.
   task automatic calibrate(input int pulse_k);
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (k == pulse_k) begin
            cmd_en = 1'b1; cmd = 1'b1; addr = 21'd8; wr_data = JUNK;
         end else begin
            cmd_en = 1'b0;
         end
         tick();
         if (k == 9) begin
            check("calib_low_c9", {63'd0, init_calib}, 64'd0);
            check("busy_high_c9", {63'd0, busy}, 64'd1);
         end
         if (k == 10) begin
            check("calib_high_c10", {63'd0, init_calib}, 64'd1);
            check("busy_low_c10", {63'd0, busy}, 64'd0);
         end
      end
      cmd_en = 1'b0;
      wr_data = '0;
   endtask

   task automatic do_write(input logic [20:0] a, input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [63:0] d3);
      cmd_en = 1'b1; cmd = 1'b1; addr = a; wr_data = d0;
      tick();
      cmd_en = 1'b0; wr_data = d1;
      tick();
      wr_data = d2;
      tick();
      wr_data = d3;
      tick();
      wr_data = '0;
   endtask

   // Issue a read and watch 30 cycles; inject_k > 0 fires a second read at that cycle.
   task automatic do_read(input logic [20:0] a, input int inject_k);
      cmd_en = 1'b1; cmd = 1'b0; addr = a;
      tick();
      cmd_en = 1'b0;
      first_k = 0;
      nvalid = 0;
      for (int i = 0; i < 4; i++) got[i] = 'x;
      for (int k = 1; k <= 30; k++) begin
         if (k == inject_k) begin
            cmd_en = 1'b1; cmd = 1'b0; addr = 21'd0;
         end else begin
            cmd_en = 1'b0;
         end
         tick();
         if (rd_data_valid) begin
            if (nvalid == 0) first_k = k;
            if (nvalid < 4) got[nvalid] = rd_data;
            nvalid++;
         end
      end
      cmd_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      tick();
      tick();
      check("rst_busy", {63'd0, busy}, 64'd1);
      check("rst_calib", {63'd0, init_calib}, 64'd0);
      check("rst_valid", {63'd0, rd_data_valid}, 64'd0);
      check("rst_rd_data", rd_data, 64'd0);

      calibrate(0);

      do_write(21'd8, W1, W2, W3, W4);
      check("wr_done_idle", {63'd0, busy}, 64'd0);

      do_read(21'd8, 0);
      check("rd8_latency", 64'(first_k), 64'd12);
      check("rd8_count", 64'(nvalid), 64'd4);
      check("rd8_w0", got[0], W1);
      check("rd8_w1", got[1], W2);
      check("rd8_w2", got[2], W3);
      check("rd8_w3", got[3], W4);

      do_read(21'd8, 13);
      check("rd_busy_latency", 64'(first_k), 64'd12);
      check("rd_busy_count", 64'(nvalid), 64'd4);
      check("rd_busy_w0", got[0], W1);
      check("rd_busy_w3", got[3], W4);

      do_read(21'h1_0008, 0);
      check("rd_alias_w0", got[0], W1);
      check("rd_alias_w1", got[1], W2);

      do_write(21'd65534, A1, A2, A3, A4);
      do_read(21'd0, 0);
      check("wrap_rd0_count", 64'(nvalid), 64'd4);
      check("wrap_rd0_w0", got[0], A3);
      check("wrap_rd0_w1", got[1], A4);
      do_read(21'd65534, 0);
      check("wrap_rdtop_w0", got[0], A1);
      check("wrap_rdtop_w1", got[1], A2);
      check("wrap_rdtop_w2", got[2], A3);
      check("wrap_rdtop_w3", got[3], A4);

      cmd_en = 1'b1; cmd = 1'b0; addr = 21'd8;
      tick();
      cmd_en = 1'b0;
      seen = 0;
      second_word = '0;
      for (int k = 1; k <= 20 && seen < 2; k++) begin
         tick();
         if (rd_data_valid) begin
            seen++;
            if (seen == 2) second_word = rd_data;
         end
      end
      check("abort_seen_two", 64'(seen), 64'd2);
      check("abort_second_word", second_word, W2);
      rst = 1'b1;
      tick();
      check("abort_valid_low", {63'd0, rd_data_valid}, 64'd0);
      check("abort_calib_low", {63'd0, init_calib}, 64'd0);
      check("abort_busy_high", {63'd0, busy}, 64'd1);

      calibrate(3);
      do_read(21'd8, 0);
      check("recal_count", 64'(nvalid), 64'd4);
      check("recal_w0", got[0], W1);
      check("recal_w1", got[1], W2);
      check("recal_w2", got[2], W3);
      check("recal_w3", got[3], W4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
